bit_vector_index_streamer: RTL and testbench

Inverse companion to the team's combinational population-count block. It accepts one VECTOR_SIZE-bit vector per transaction and streams out the index of every set bit, LSB first, one index per cycle under valid/ready backpressure. Each beat carries its ordinal, a last flag, and the total set-bit count, so a consumer can serialise sparse bit masks (request masks, free lists).

---
 rtl/bit_vector_pkg.sv | 30 +++
 rtl/bit_vector_index_streamer_if.sv | 31 +++
 rtl/lsb_first_one.sv | 29 ++
 rtl/bit_vector_index_streamer.sv | 96 +++++++++
 tb/tb_bit_vector_index_streamer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_vector_pkg.sv
// rtl/bit_vector_pkg.sv - shared types and helpers for the bit-vector index streamer
package bit_vector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Widest vector popcount() accepts; callers zero-extend into it.
  localparam int MAX_VEC_W = 256;

  function automatic int idx_width(input int vector_size);
    return $clog2(vector_size);
  endfunction

  // One extra bit so an all-ones vector's count fits without wrapping.
  function automatic int cnt_width(input int vector_size);
    return $clog2(vector_size) + 1;
  endfunction

  function automatic int popcount(input logic [MAX_VEC_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bit_vector_index_streamer_if.sv
// rtl/bit_vector_index_streamer_if.sv - vector-in / index-beat-out handshake bundle
interface bit_vector_index_streamer_if #(
  parameter int VECTOR_SIZE = 16
);
  import bit_vector_pkg::*;

  localparam int IDX_W = idx_width(VECTOR_SIZE);
  localparam int CNT_W = cnt_width(VECTOR_SIZE);

  logic                   in_valid;
  logic                   in_ready;
  logic [VECTOR_SIZE-1:0] in_vector;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_idx;
  logic [CNT_W-1:0]       out_seq;
  logic                   out_last;
  logic                   out_empty;
  logic [CNT_W-1:0]       out_count;

  modport master (
    output in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_idx, out_seq, out_last, out_empty, out_count
  );

  modport slave (
    input  in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_idx, out_seq, out_last, out_empty, out_count
  );

endinterface

// File: rtl/lsb_first_one.sv
// rtl/lsb_first_one.sv - lowest set bit finder: index, any/single flags, vector with that bit cleared
module lsb_first_one
  import bit_vector_pkg::*;
#(
  parameter  int VECTOR_SIZE = 16,
  localparam int IDX_W       = idx_width(VECTOR_SIZE)
) (
  input  logic [VECTOR_SIZE-1:0] vec,
  output logic [IDX_W-1:0]       idx,
  output logic                   any,
  output logic                   single,
  output logic [VECTOR_SIZE-1:0] cleared
);

  assign cleared = vec & (vec - VECTOR_SIZE'(1));
  assign any     = |vec;
  assign single  = any && (cleared == '0);

  // Scan downward so the lowest set bit is the final write.
  always_comb begin
    idx = '0;
    for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bit_vector_index_streamer.sv
// rtl/bit_vector_index_streamer.sv - streams the index of every set bit of a captured vector, LSB first
module bit_vector_index_streamer
  import bit_vector_pkg::*;
#(
  parameter int VECTOR_SIZE = 16
) (
  input logic                        clk,
  input logic                        rst,
  bit_vector_index_streamer_if.slave bus
);

  localparam int IDX_W = idx_width(VECTOR_SIZE);
  localparam int CNT_W = cnt_width(VECTOR_SIZE);

  state_e                 state_q, state_d;
  logic [VECTOR_SIZE-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]       seq_q, seq_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   empty_q, empty_d;

  logic [IDX_W-1:0]       low_idx;
  logic                   any_set;
  logic                   single_set;
  logic [VECTOR_SIZE-1:0] cleared;
  logic                   last;

  lsb_first_one #(.VECTOR_SIZE(VECTOR_SIZE)) u_lsb (
    .vec     (pending_q),
    .idx     (low_idx),
    .any     (any_set),
    .single  (single_set),
    .cleared (cleared)
  );

  // An empty pending vector in BUSY is the single all-zero beat.
  assign last = (state_q == BUSY) && (single_set || !any_set);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    seq_d     = seq_q;
    count_d   = count_q;
    empty_d   = empty_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_vector;
          count_d   = CNT_W'(popcount(MAX_VEC_W'(bus.in_vector)));
          seq_d     = '0;
          empty_d   = (bus.in_vector == '0);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (last) begin
            state_d   = IDLE;
            pending_d = '0;
            seq_d     = '0;
            count_d   = '0;
            empty_d   = 1'b0;
          end else begin
            pending_d = cleared;
            seq_d     = seq_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      seq_q     <= '0;
      count_q   <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == BUSY);
  assign bus.out_idx   = low_idx;
  assign bus.out_seq   = seq_q;
  assign bus.out_last  = last;
  assign bus.out_empty = empty_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_bit_vector_index_streamer.sv
// tb/tb_bit_vector_index_streamer.sv - scoreboard bench for the bit-vector index streamer
module tb_bit_vector_index_streamer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit_vector_index_streamer_if #(.VECTOR_SIZE(16)) bus16 ();
  bit_vector_index_streamer_if #(.VECTOR_SIZE(2))  bus2 ();

  bit_vector_index_streamer #(.VECTOR_SIZE(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  bit_vector_index_streamer #(.VECTOR_SIZE(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int idx;
    int seq;
    int last;
    int empty;
    int cnt;
  } beat_t;

  beat_t sb16[$];
  beat_t exp_b;
  beat_t held;
  logic  stalled = 1'b0;

  int tests_run     = 0;
  int tests_failed  = 0;
  int cyc           = 0;
  int last_xfer_cyc = -100;
  int last_acc_cyc  = -100;
  int n;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_model(input logic [15:0] v);
    int cnt;
    int k;
    cnt = 0;
    k   = 0;
    for (int i = 0; i < 16; i++) cnt += int'(v[i]);
    if (cnt == 0) begin
      sb16.push_back('{idx: 0, seq: 0, last: 1, empty: 1, cnt: 0});
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) begin
          sb16.push_back('{idx: i, seq: k, last: int'(k == cnt - 1), empty: 0, cnt: cnt});
          k++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (bus16.in_valid && bus16.in_ready) begin
        push_model(bus16.in_vector);
        last_acc_cyc = cyc;
      end
      if (stalled) begin
        check_eq("hold_valid", int'(bus16.out_valid), 1);
        check_eq("hold_idx",   int'(bus16.out_idx),   held.idx);
        check_eq("hold_seq",   int'(bus16.out_seq),   held.seq);
        check_eq("hold_last",  int'(bus16.out_last),  held.last);
        check_eq("hold_count", int'(bus16.out_count), held.cnt);
      end
      if (bus16.out_valid && bus16.out_ready) begin
        check_eq("sb_nonempty", int'(sb16.size() != 0), 1);
        if (sb16.size() != 0) begin
          exp_b = sb16.pop_front();
          check_eq("beat_idx",   int'(bus16.out_idx),   exp_b.idx);
          check_eq("beat_seq",   int'(bus16.out_seq),   exp_b.seq);
          check_eq("beat_last",  int'(bus16.out_last),  exp_b.last);
          check_eq("beat_empty", int'(bus16.out_empty), exp_b.empty);
          check_eq("beat_count", int'(bus16.out_count), exp_b.cnt);
        end
        if (bus16.out_last) last_xfer_cyc = cyc;
      end
      stalled = bus16.out_valid && !bus16.out_ready;
      held = '{idx: int'(bus16.out_idx), seq: int'(bus16.out_seq), last: int'(bus16.out_last),
               empty: int'(bus16.out_empty), cnt: int'(bus16.out_count)};
    end
  end

  task automatic send16(input logic [15:0] v);
    int w;
    w = 0;
    bus16.in_valid  = 1'b1;
    bus16.in_vector = v;
    @(negedge clk);
    while (!bus16.in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    check_eq("send_ready", int'(bus16.in_ready), 1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic busy_cycles16(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!bus16.in_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus16.in_valid  = 1'b0;
    bus16.in_vector = '0;
    bus16.out_ready = 1'b1;
    bus2.in_valid   = 1'b0;
    bus2.in_vector  = '0;
    bus2.out_ready  = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_in_ready",  int'(bus16.in_ready),  1);
    check_eq("rst_out_valid", int'(bus16.out_valid), 0);
    check_eq("rst_out_idx",   int'(bus16.out_idx),   0);
    check_eq("rst_out_seq",   int'(bus16.out_seq),   0);
    check_eq("rst_out_last",  int'(bus16.out_last),  0);
    check_eq("rst_out_empty", int'(bus16.out_empty), 0);
    check_eq("rst_out_count", int'(bus16.out_count), 0);
    check_eq("rst2_in_ready", int'(bus2.in_ready),   1);
    check_eq("rst2_valid",    int'(bus2.out_valid),  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Sparse vector at full throughput
    send16(16'h8421);
    busy_cycles16(n);
    check_eq("busy_8421", n, 4);
    check_eq("drained_8421", sb16.size(), 0);

    // Zero vector: one empty beat, then ready again
    send16(16'h0000);
    busy_cycles16(n);
    check_eq("busy_zero", n, 1);
    check_eq("drained_zero", sb16.size(), 0);

    // Full vector with three stall cycles on the first beat
    bus16.out_ready = 1'b0;
    send16(16'hFFFF);
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_valid", int'(bus16.out_valid), 1);
      check_eq("stall_idx",   int'(bus16.out_idx),   0);
      check_eq("stall_seq",   int'(bus16.out_seq),   0);
      @(posedge clk);
      #1;
    end
    bus16.out_ready = 1'b1;
    busy_cycles16(n);
    check_eq("busy_ffff", n, 16);
    check_eq("drained_ffff", sb16.size(), 0);

    // in_valid held across two vectors with out_ready toggling
    bus16.in_valid  = 1'b1;
    bus16.in_vector = 16'h0006;
    @(posedge clk);
    #1 bus16.in_vector = 16'h0100;
    @(posedge clk);
    #1 bus16.out_ready = 1'b0;
    @(posedge clk);
    #1 bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    check_eq("accept_gap", last_acc_cyc - last_xfer_cyc, 1);
    busy_cycles16(n);
    check_eq("busy_0100", n, 1);
    check_eq("drained_0100", sb16.size(), 0);

    // Reset mid-burst after two beats
    send16(16'h00F0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sb16.delete();
    #1;
    check_eq("midrst_valid",    int'(bus16.out_valid), 0);
    check_eq("midrst_in_ready", int'(bus16.in_ready),  1);
    check_eq("midrst_count",    int'(bus16.out_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send16(16'h0003);
    busy_cycles16(n);
    check_eq("busy_0003", n, 2);
    check_eq("drained_0003", sb16.size(), 0);

    // Two-bit instance: single high bit, then both bits set
    bus2.in_valid  = 1'b1;
    bus2.in_vector = 2'b10;
    @(negedge clk);
    check_eq("v2_in_ready", int'(bus2.in_ready), 1);
    @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    @(negedge clk);
    check_eq("v2_valid", int'(bus2.out_valid), 1);
    check_eq("v2_idx",   int'(bus2.out_idx),   1);
    check_eq("v2_seq",   int'(bus2.out_seq),   0);
    check_eq("v2_last",  int'(bus2.out_last),  1);
    check_eq("v2_count", int'(bus2.out_count), 1);
    check_eq("v2_empty", int'(bus2.out_empty), 0);
    @(negedge clk);
    check_eq("v2_idle_valid", int'(bus2.out_valid), 0);
    check_eq("v2_idle_ready", int'(bus2.in_ready),  1);
    @(posedge clk);
    #1;
    bus2.in_valid  = 1'b1;
    bus2.in_vector = 2'b11;
    @(posedge clk);
    #1 bus2.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("v2f_valid", int'(bus2.out_valid), 1);
      check_eq("v2f_idx",   int'(bus2.out_idx),   k);
      check_eq("v2f_seq",   int'(bus2.out_seq),   k);
      check_eq("v2f_last",  int'(bus2.out_last),  int'(k == 1));
      check_eq("v2f_count", int'(bus2.out_count), 2);
    end
    @(negedge clk);
    check_eq("v2f_done", int'(bus2.out_valid), 0);

    check_eq("sb_final_empty", sb16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
